// File: rtl/board_io_hub.sv
// rtl/board_io_hub.sv - board pin hub: switch sync, button debounce, LED register, 7-seg scanner
//
// Purpose: sits between raw board pins and a user core so the core sees clean,
// synchronous values and drives plain LED/display values.
//
// Ports:
//   clk         in  1             single clock
//   rst         in  1             synchronous active-low reset
//   sw          in  SWITCH_COUNT  raw switches (asynchronous)
//   btn         in  BUTTON_COUNT  raw buttons (asynchronous, bouncing)
//   led         out LED_COUNT     registered LED drive
//   seg         out 8             segments {dp, g..a}, active-high
//   an          out SEG_COUNT     one-hot digit enable, active-high
//   sw_sync     out SWITCH_COUNT  synchronised switches
//   btn_level   out BUTTON_COUNT  debounced button level
//   btn_press   out BUTTON_COUNT  one-cycle pulse on debounced rise
//   led_in      in  LED_COUNT     core LED request
//   disp_value  in  4*SEG_COUNT   hex nibble per digit
//   disp_dp     in  SEG_COUNT     decimal point per digit
//   disp_en     in  SEG_COUNT     digit enable (0 = blank)

module board_io_hub #(
  parameter int LED_COUNT       = 8,
  parameter int SWITCH_COUNT    = 8,
  parameter int BUTTON_COUNT    = 4,
  parameter int SEG_COUNT       = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SWITCH_COUNT-1:0] sw,
  input  logic [BUTTON_COUNT-1:0] btn,
  output logic [LED_COUNT-1:0]    led,
  output logic [7:0]              seg,
  output logic [SEG_COUNT-1:0]    an,
  output logic [SWITCH_COUNT-1:0] sw_sync,
  output logic [BUTTON_COUNT-1:0] btn_level,
  output logic [BUTTON_COUNT-1:0] btn_press,
  input  logic [LED_COUNT-1:0]    led_in,
  input  logic [4*SEG_COUNT-1:0]  disp_value,
  input  logic [SEG_COUNT-1:0]    disp_dp,
  input  logic [SEG_COUNT-1:0]    disp_en
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(SEG_COUNT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SWITCH_COUNT-1:0]           sw_s1_q, sw_s2_q;
  logic [BUTTON_COUNT-1:0]           btn_s1_q, btn_s2_q;
  logic [BUTTON_COUNT-1:0][CW-1:0]   db_cnt_q, db_cnt_d;
  logic [BUTTON_COUNT-1:0]           level_q, level_d;
  logic [BUTTON_COUNT-1:0]           press_q, press_d;
  logic [LED_COUNT-1:0]              led_q;
  logic [PW-1:0]                     presc_q, presc_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic [7:0]                        seg_q, seg_d;
  logic [SEG_COUNT-1:0]              an_q, an_d;

  // ---------------------------------------------------------------------------
  // Hex to seven-segment (g..a), active-high
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h3F;
      4'h1: r = 7'h06;
      4'h2: r = 7'h5B;
      4'h3: r = 7'h4F;
      4'h4: r = 7'h66;
      4'h5: r = 7'h6D;
      4'h6: r = 7'h7D;
      4'h7: r = 7'h07;
      4'h8: r = 7'h7F;
      4'h9: r = 7'h6F;
      4'hA: r = 7'h77;
      4'hB: r = 7'h7C;
      4'hC: r = 7'h39;
      4'hD: r = 7'h5E;
      4'hE: r = 7'h79;
      default: r = 7'h71;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Debounce: a button level is accepted only after the synchronised input has
  // disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles.
  // Any cycle of agreement restarts the count.
  // ---------------------------------------------------------------------------
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    press_d  = '0;
    for (int i = 0; i < BUTTON_COUNT; i++) begin
      if (btn_s2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = btn_s2_q[i];
          // Pulse only on an accepted rise; releases are silent.
          press_d[i] = btn_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scanner: prescaler paces the digit index; seg/an are registered from the
  // current index so each digit occupies exactly SCAN_DIV output cycles.
  // ---------------------------------------------------------------------------
  logic [3:0] sel_nib;
  logic       sel_dp;
  logic       sel_en;

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    sel_nib = 4'h0;
    sel_dp  = 1'b0;
    sel_en  = 1'b0;
    an_d    = '0;
    for (int i = 0; i < SEG_COUNT; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib = disp_value[4*i +: 4];
        sel_dp  = disp_dp[i];
        sel_en  = disp_en[i];
        an_d[i] = disp_en[i];
      end
    end
    seg_d = sel_en ? {sel_dp, hex7(sel_nib)} : 8'h00;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      db_cnt_q <= '0;
      level_q  <= '0;
      press_q  <= '0;
      led_q    <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= '0;
      an_q     <= '0;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      led_q    <= led_in;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign sw_sync   = sw_s2_q;
  assign btn_level = level_q;
  assign btn_press = press_q;
  assign led       = led_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule
